// File: rtl/serial_frame_pkg.sv
// Shared types and constants for the serial frame receiver.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Holds the receiver state enumeration, the start/stop line levels, and a
// small helper that computes even parity over a payload word.
package serial_frame_pkg;

  // Receiver FSM states. IDLE must encode to zero so that busy can be
  // derived by comparing against it.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } rx_state_e;

  // Line level of the start bit that opens a frame.
  localparam logic START_LVL = 1'b0;
  // Line level required in the stop slot for a frame to be accepted.
  localparam logic STOP_LVL  = 1'b1;

  // Even parity of a single received bit folded into a running accumulator.
  function automatic logic parity_fold(input logic acc, input logic bit_in);
    return acc ^ bit_in;
  endfunction

endpackage

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, DATA_W payload bits LSB first, optional even parity, stop bit.
// Latency: dout/dout_valid and error pulses appear 1 clock after the edge that strobes the stop bit.
// Backpressure: one-entry output register; a good frame arriving while it is full and not being
//   drained is dropped and flagged with a one-cycle overrun pulse.
//
// Ports:
//   c          clock, all state changes on its rising edge
//   rst        asynchronous active-low reset
//   sin        serial input bit, sampled only when sin_en = 1
//   sin_en     bit strobe
//   dout       received payload (valid while dout_valid = 1)
//   dout_valid dout holds a frame not yet accepted
//   dout_ready consumer accepts dout on an edge where dout_valid & dout_ready
//   busy       receiver is inside a frame (any state other than IDLE)
//   parity_err one-cycle pulse: frame dropped for parity mismatch
//   frame_err  one-cycle pulse: frame dropped because the stop bit was low
//   overrun    one-cycle pulse: good frame dropped because dout was still occupied
module serial_frame_rx
  import serial_frame_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int PARITY_EN = 1
) (
  input  logic              c,
  input  logic              rst,
  input  logic              sin,
  input  logic              sin_en,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              busy,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun
);

  // The bit counter only has to reach DATA_W-1.
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  rx_state_e         state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] shift_d;
  logic              par_q;        // running XOR of payload bits
  logic              par_d;
  logic              perr_q;       // parity mismatch seen in this frame
  logic [DATA_W-1:0] dout_q;
  logic              dout_valid_q;
  logic              parity_err_q;
  logic              frame_err_q;
  logic              overrun_q;

  logic              take_out;     // consumer accepts the current dout on this edge
  logic              stop_edge;    // stop bit is strobed on this edge
  logic              frame_good;   // stop slot valid and parity clean
  logic              out_free;     // output register can accept a new frame this edge

  // Payload arrives LSB first, so each new bit enters at the MSB and the
  // word slides right; after DATA_W bits the first bit sits at bit 0.
  always_comb begin
    shift_d             = shift_q >> 1;
    shift_d[DATA_W-1]   = sin;
    par_d               = parity_fold(par_q, sin);
  end

  always_comb begin
    take_out   = dout_valid_q & dout_ready;
    stop_edge  = sin_en & (state_q == ST_STOP);
    frame_good = (sin == STOP_LVL) & ~perr_q;
    // A handshake on the same edge frees the slot for the incoming frame.
    out_free   = ~dout_valid_q | dout_ready;
  end

  always_ff @(posedge c or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      perr_q       <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      // Error indications are single-cycle pulses.
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;

      if (take_out) begin
        dout_valid_q <= 1'b0;
      end

      if (sin_en) begin
        unique case (state_q)
          ST_IDLE: begin
            if (sin == START_LVL) begin
              state_q <= ST_DATA;
              cnt_q   <= '0;
              shift_q <= '0;
              par_q   <= 1'b0;
              perr_q  <= 1'b0;
            end
          end

          ST_DATA: begin
            shift_q <= shift_d;
            par_q   <= par_d;
            if (cnt_q == CNT_LAST) begin
              cnt_q   <= '0;
              state_q <= (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end

          ST_PARITY: begin
            // Even parity: the parity bit equals the XOR of the payload.
            perr_q  <= sin ^ par_q;
            state_q <= ST_STOP;
          end

          ST_STOP: begin
            state_q <= ST_IDLE;
          end

          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end

      // Frame disposition is decided on the stop edge. A low stop bit wins
      // over a parity mismatch so that only one error is reported.
      if (stop_edge) begin
        if (sin != STOP_LVL) begin
          frame_err_q <= 1'b1;
        end else if (perr_q) begin
          parity_err_q <= 1'b1;
        end else if (frame_good && out_free) begin
          dout_q       <= shift_q;
          dout_valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign busy       = (state_q != ST_IDLE);
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Scoreboard bench for serial_frame_rx (DATA_W = 8, PARITY_EN = 1).
// Stimulus pushes the expected output event before driving each frame; a
// separate monitor detects loads and error pulses and pops/compares.
module tb_serial_frame_rx;

  localparam int K_LOAD = 0;
  localparam int K_PERR = 1;
  localparam int K_FERR = 2;
  localparam int K_OVR  = 3;

  typedef struct {
    int         kind;
    logic [7:0] data;
  } exp_t;

  logic       c;
  logic       rst;
  logic       sin;
  logic       sin_en;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic       busy;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;

  int   total;
  int   bad;
  exp_t exp_q[$];

  logic prev_valid;
  logic prev_ready;

  serial_frame_rx #(
    .DATA_W    (8),
    .PARITY_EN (1)
  ) dut (
    .c          (c),
    .rst        (rst),
    .sin        (sin),
    .sin_en     (sin_en),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .busy       (busy),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  initial c = 1'b0;
  always #5 c = ~c;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int kind, input logic [7:0] data);
    exp_t e;
    e.kind = kind;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Called by the monitor for every observed output event.
  task automatic got(input int kind, input logic [7:0] data);
    exp_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_event: got kind %0d data 0x%0h expected none at %0t", kind, data, $time);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", kind, e.kind);
      if (e.kind == K_LOAD && kind == K_LOAD) begin
        check("load_data", int'(data), int'(e.data));
      end
    end
  endtask

  // A load is seen when dout_valid is high now and either was low at the
  // previous sample or the previous sample showed a handshake.
  always @(negedge c) begin
    if (!rst) begin
      prev_valid = 1'b0;
      prev_ready = 1'b0;
    end else begin
      if (dout_valid && (!prev_valid || prev_ready)) got(K_LOAD, dout);
      if (parity_err) got(K_PERR, 8'h00);
      if (frame_err)  got(K_FERR, 8'h00);
      if (overrun)    got(K_OVR,  8'h00);
      prev_valid = dout_valid;
      prev_ready = dout_ready;
    end
  end

  // Drives start, 8 data bits LSB first, parity (optionally inverted) and
  // the stop bit. gap = number of unstrobed clocks after each bit.
  task automatic send_frame(input logic [7:0] d, input logic pflip, input logic stop,
                            input int gap, input logic rdy_on_stop);
    logic [10:0] bits;
    bits[0]    = 1'b0;
    bits[8:1]  = d;
    bits[9]    = (^d) ^ pflip;
    bits[10]   = stop;
    for (int i = 0; i < 11; i++) begin
      sin    = bits[i];
      sin_en = 1'b1;
      if (i == 10 && rdy_on_stop) dout_ready = 1'b1;
      @(posedge c); #1;
      if (i == 10 && rdy_on_stop) dout_ready = 1'b0;
      sin_en = 1'b0;
      sin    = 1'b1;
      for (int g = 0; g < gap; g++) begin
        @(posedge c); #1;
        if (i < 10) check("hold_busy", int'(busy), 1);
      end
    end
  endtask

  task automatic idle(input int n);
    sin    = 1'b1;
    sin_en = 1'b0;
    repeat (n) begin
      @(posedge c); #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish at %0t", $time);
    $fatal(1);
  end

  initial begin
    total      = 0;
    bad        = 0;
    rst        = 1'b0;
    sin        = 1'b1;
    sin_en     = 1'b0;
    dout_ready = 1'b1;

    // Reset state
    #3;
    check("rst_dout",  int'(dout), 0);
    check("rst_valid", int'(dout_valid), 0);
    check("rst_busy",  int'(busy), 0);
    check("rst_perr",  int'(parity_err), 0);
    check("rst_ferr",  int'(frame_err), 0);
    check("rst_ovr",   int'(overrun), 0);
    repeat (2) @(posedge c);
    #1 rst = 1'b1;
    idle(2);

    // Good frame 0xA5, visible one clock after the stop edge
    push(K_LOAD, 8'hA5);
    send_frame(8'hA5, 1'b0, 1'b1, 0, 1'b0);
    check("a5_valid", int'(dout_valid), 1);
    check("a5_dout",  int'(dout), 'hA5);
    check("a5_busy",  int'(busy), 0);
    idle(2);
    check("a5_consumed", int'(dout_valid), 0);

    // Parity error, frame error, and both (frame error wins)
    push(K_PERR, 8'h00);
    send_frame(8'hA5, 1'b1, 1'b1, 0, 1'b0);
    check("perr_no_valid", int'(dout_valid), 0);
    idle(2);
    push(K_FERR, 8'h00);
    send_frame(8'hA5, 1'b0, 1'b0, 0, 1'b0);
    check("ferr_no_valid", int'(dout_valid), 0);
    idle(2);
    push(K_FERR, 8'h00);
    send_frame(8'hA5, 1'b1, 1'b0, 0, 1'b0);
    idle(2);

    // Overrun with back-to-back frames, then a one-cycle drain
    dout_ready = 1'b0;
    push(K_LOAD, 8'h3C);
    send_frame(8'h3C, 1'b0, 1'b1, 0, 1'b0);
    push(K_OVR, 8'h00);
    send_frame(8'h0F, 1'b0, 1'b1, 0, 1'b0);
    idle(2);
    check("ovr_dout",  int'(dout), 'h3C);
    check("ovr_valid", int'(dout_valid), 1);
    dout_ready = 1'b1;
    @(posedge c); #1;
    dout_ready = 1'b0;
    check("ovr_drained", int'(dout_valid), 0);
    idle(2);

    // Handshake on the same edge as a new good frame completes
    push(K_LOAD, 8'h12);
    send_frame(8'h12, 1'b0, 1'b1, 0, 1'b0);
    idle(2);
    push(K_LOAD, 8'h34);
    send_frame(8'h34, 1'b0, 1'b1, 0, 1'b1);
    check("same_edge_dout",  int'(dout), 'h34);
    check("same_edge_valid", int'(dout_valid), 1);
    idle(2);
    check("same_edge_hold", int'(dout), 'h34);
    dout_ready = 1'b1;
    idle(2);
    check("same_edge_drained", int'(dout_valid), 0);

    // Strobe every 4th clock
    push(K_LOAD, 8'h81);
    send_frame(8'h81, 1'b0, 1'b1, 3, 1'b0);
    check("slow_dout", int'(dout), 'h81);
    idle(3);

    // Reset after start bit and 3 data bits
    sin = 1'b0; sin_en = 1'b1;
    @(posedge c); #1;
    sin = 1'b1; @(posedge c); #1;
    sin = 1'b0; @(posedge c); #1;
    sin = 1'b1; @(posedge c); #1;
    check("mid_busy", int'(busy), 1);
    sin_en = 1'b0;
    rst    = 1'b0;
    #1;
    check("mid_rst_dout",  int'(dout), 0);
    check("mid_rst_valid", int'(dout_valid), 0);
    check("mid_rst_busy",  int'(busy), 0);
    check("mid_rst_errs",  int'({parity_err, frame_err, overrun}), 0);
    @(posedge c); #1;
    rst = 1'b1;
    idle(2);
    push(K_LOAD, 8'h55);
    send_frame(8'h55, 1'b0, 1'b1, 0, 1'b0);
    check("after_rst_dout", int'(dout), 'h55);
    idle(5);

    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
